coincidence_histogram: RTL and testbench
========================================

COINCIDENCE_HISTOGRAM -- requirements
Module: coincidence_histogram

Interface
REQ-001 SHALL have parameter BIN_W, default 16, width of each histogram bin counter.
REQ-002 SHALL have parameter CNT_W, default 32, width of event_count.
REQ-003 SHALL have port clk, input, 1: single clock, 500 MHz, same domain as the TDC.
REQ-004 SHALL have port rst, input, 1: reset; synchronous and active-high.
REQ-005 SHALL have port START_signal, input, 2: TDC start-channel code.
REQ-006 SHALL have port END_signal, input, 2: TDC end-channel code.
REQ-007 SHALL have port INTERVAL, input, 6: TDC delay in clk cycles.
REQ-008 SHALL have port data_arrived, input, 1: TDC event strobe; high 1–2 cycles.
REQ-009 SHALL have port acq_en, input, 1: acquisition enable.
REQ-010 SHALL have port clear, input, 1: single-cycle request to zero all bins and counters.
REQ-011 SHALL have port busy, output, 1: high while the clear sweep runs.
REQ-012 SHALL have port rd_req, input, 1: bin read request.
REQ-013 SHALL have port rd_addr, input, 7: bin address; 0–63 is H12, 64–127 is H21.
REQ-014 SHALL have port rd_data, output, BIN_W: read result.
REQ-015 SHALL have port rd_valid, output, 1: rd_data qualifier; single-cycle pulse.
REQ-016 SHALL have port event_count, output, CNT_W: count of accepted events.
REQ-017 SHALL have port drop_count, output, 16: count of discarded events.

Function
REQ-018 SHALL detect an event only on the cycle where data_arrived=1 and its registered previous value was 0; the second high cycle of a strobe SHALL NOT be counted again.
REQ-019 SHALL register START_signal, END_signal and INTERVAL in the detection cycle (cycle N).
REQ-020 SHALL classify the captured event as follows:
- START=01, END=10: increment H12[INTERVAL].
- START=10, END=01: increment H21[INTERVAL].
- END=11: increment H12[0] and H21[0] in the same cycle.
- Any other code: discard.
REQ-021 SHALL commit bin and event_count updates at clock edge N+1; a read issued at N+1 SHALL return the updated value.
REQ-022 SHALL saturate bins at 2^BIN_W-1, and saturate event_count and drop_count at all-ones.
REQ-023 SHALL ignore events while acq_en=0; no counter changes.
REQ-024 SHALL increment drop_count once for each discarded event, including events that arrive while busy=1 with acq_en=1.
REQ-025 SHALL respond to rd_req=1 at edge N (busy=0) with rd_data=bin[rd_addr] and rd_valid=1 at edge N+1. Reads are back-to-back capable.
REQ-026 SHALL return the pre-increment value when a read and an increment target the same bin in the same cycle.
REQ-027 SHALL ignore rd_req while busy=1; rd_valid stays 0.
REQ-028 SHALL run the clear state machine IDLE→SWEEP→IDLE:
- clear=1 in IDLE: zero event_count and drop_count and set busy=1 at the next edge.
- SWEEP: zero one bin per cycle, addresses 0..127 in order.
- After bin 127: return to IDLE with busy=0 (busy high exactly 128 cycles).
REQ-029 SHALL ignore clear while in SWEEP.

Reset
REQ-030 SHALL, with rst=1, hold rd_valid=0, rd_data=0, event_count=0, drop_count=0, busy=1, and the sweep address at 0.
REQ-031 SHALL, on rst release, perform a full SWEEP per REQ-028, so all bins are 0 before the first accepted event.
REQ-032 SHALL restart the sweep from address 0 if rst is asserted mid-sweep or mid-acquisition; a pending capture SHALL be dropped and not counted.

Configuration
REQ-033 SHALL, when CLEAR_ON_READ_EN is defined, zero the bin being read at edge N+1 while rd_data returns the old value. If an increment hits the same bin in that cycle, the bin SHALL become 1.
REQ-034 SHALL, when CLEAR_ON_READ_EN is undefined, leave reads non-destructive.

Structure
REQ-035 SHALL take N_BINS=64, N_ADDR=128, and the event-class enum (EV_H12, EV_H21, EV_ZERO, EV_DROP) from shared package tca_pkg.
REQ-036 SHALL place strobe edge detection, capture and classification in sub-module tdc_event_decoder, which outputs a one-cycle valid, the class and the bin index.

Verification
REQ-037 SHALL cover: after reset plus 128 cycles, read addr 5 → rd_data=0, rd_valid one cycle later; busy low.
REQ-038 SHALL cover: event START=01, END=10, INTERVAL=10 with data_arrived held 2 cycles → H12[10]=1, event_count=1.
REQ-039 SHALL cover: event END=11, INTERVAL=0 → H12[0]=1 and H21[0]=1; event START=01, END=01 → drop_count=1.
REQ-040 SHALL cover: preload H21[63]=0xFFFE, then 3 events START=10, END=01, INTERVAL=63 → bin=0xFFFF (saturated), event_count=3.
REQ-041 SHALL cover: clear, then an event at sweep cycle 50 → busy high 128 cycles, drop_count=1, all bins 0 afterwards.
REQ-042 SHALL cover: CLEAR_ON_READ_EN defined, H12[7]=4, read addr 7 twice → returns 4, then 0.

Source files
------------

// File: rtl/tca_pkg.sv
// ============================================================================
//  Module      : tca_pkg
//  Description : Shared histogram geometry and TDC event classes.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package tca_pkg;

    localparam int N_BINS = 64;
    localparam int N_ADDR = 128;

    typedef enum logic [1:0] {
        EV_H12  = 2'd0,
        EV_H21  = 2'd1,
        EV_ZERO = 2'd2,
        EV_DROP = 2'd3
    } ev_class_e;

    // END=11 marks a zero-delay coincidence regardless of the start code.
    function automatic ev_class_e classify(input logic [1:0] start_code,
                                           input logic [1:0] end_code);
        ev_class_e cls;
        cls = EV_DROP;
        if (end_code == 2'b11)
            cls = EV_ZERO;
        else if (start_code == 2'b01 && end_code == 2'b10)
            cls = EV_H12;
        else if (start_code == 2'b10 && end_code == 2'b01)
            cls = EV_H21;
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/coincidence_histogram_if.sv
// ============================================================================
//  Module      : coincidence_histogram_if
//  Description : Bin read bus of the coincidence histogram.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface coincidence_histogram_if #(
    parameter int BIN_W = 16
);
    logic             rd_req;
    logic [6:0]       rd_addr;
    logic [BIN_W-1:0] rd_data;
    logic             rd_valid;

    modport master (output rd_req, rd_addr, input rd_data, rd_valid);
    modport slave  (input rd_req, rd_addr, output rd_data, rd_valid);
endinterface

`default_nettype wire

// File: rtl/tdc_event_decoder.sv
// ============================================================================
//  Module      : tdc_event_decoder
//  Description : Strobe edge detect, capture and classification of TDC events.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tdc_event_decoder
    import tca_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] i_start_code,
    input  wire logic [1:0] i_end_code,
    input  wire logic [5:0] i_interval,
    input  wire logic       i_data_arrived,
    input  wire logic       i_acq_en,
    output logic            o_valid,
    output ev_class_e       o_class,
    output logic [5:0]      o_bin
);

    logic      r_da_prev;
    logic      r_valid;
    ev_class_e r_class;
    logic [5:0] r_bin;
    logic      w_edge;

    // Only the rising edge of the strobe counts; a two-cycle strobe is one event.
    assign w_edge = i_data_arrived & ~r_da_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_da_prev <= 1'b0;
            r_valid   <= 1'b0;
            r_class   <= EV_DROP;
            r_bin     <= '0;
        end else begin
            r_da_prev <= i_data_arrived;
            r_valid   <= w_edge & i_acq_en;
            if (w_edge) begin
                r_class <= classify(i_start_code, i_end_code);
                r_bin   <= i_interval;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_class = r_class;
    assign o_bin   = r_bin;

endmodule

`default_nettype wire

// File: rtl/coincidence_histogram.sv
// ============================================================================
//  Module      : coincidence_histogram
//  Description : Two 64-bin TDC delay histograms (H12, H21) with clear sweep.
//                Define CLEAR_ON_READ_EN for destructive (clear-on-read) reads.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module coincidence_histogram
    import tca_pkg::*;
#(
    parameter int BIN_W = 16,
    parameter int CNT_W = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [1:0]       START_signal,
    input  wire logic [1:0]       END_signal,
    input  wire logic [5:0]       INTERVAL,
    input  wire logic             data_arrived,
    input  wire logic             acq_en,
    input  wire logic             clear,
    output logic                  busy,
    coincidence_histogram_if.slave rd,
    output logic [CNT_W-1:0]      event_count,
    output logic [15:0]           drop_count
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SWEEP = 1'b1;
    localparam logic [6:0] c_H21_BASE = 7'(N_BINS);
    localparam logic [6:0] c_LAST     = 7'(N_ADDR - 1);

    logic             w_ev_valid;
    ev_class_e        w_ev_class;
    logic [5:0]       w_ev_bin;

    logic [0:0]       r_state;
    logic [6:0]       r_sweep_addr;
    logic             r_busy;
    logic             r_rd_valid;
    logic [BIN_W-1:0] r_rd_data;
    logic [CNT_W-1:0] r_event_count;
    logic [15:0]      r_drop_count;
    logic [BIN_W-1:0] r_bins [N_ADDR];

    logic             w_sweeping;
    logic             w_commit;
    logic             w_accept;
    logic             w_drop;
    logic             w_rd_fire;
    logic             w_cor_fire;
    logic             w_inc_a_en;
    logic             w_inc_b_en;
    logic [6:0]       w_inc_a_addr;
    logic [BIN_W-1:0] w_base_a;
    logic [BIN_W-1:0] w_base_b;

    function automatic logic [BIN_W-1:0] sat_inc(input logic [BIN_W-1:0] v);
        return (&v) ? v : v + BIN_W'(1);
    endfunction

    tdc_event_decoder u_decoder (
        .clk            (clk),
        .rst            (rst),
        .i_start_code   (START_signal),
        .i_end_code     (END_signal),
        .i_interval     (INTERVAL),
        .i_data_arrived (data_arrived),
        .i_acq_en       (acq_en),
        .o_valid        (w_ev_valid),
        .o_class        (w_ev_class),
        .o_bin          (w_ev_bin)
    );

    assign w_sweeping = (r_state == c_ST_SWEEP);
    assign w_commit   = w_ev_valid & ~w_sweeping & ~rst;
    assign w_accept   = w_commit & (w_ev_class != EV_DROP);
    // Events landing during a sweep are lost, so they are accounted as drops.
    assign w_drop     = w_ev_valid & (w_sweeping | (w_ev_class == EV_DROP));
    assign w_rd_fire  = rd.rd_req & ~w_sweeping;
    assign w_inc_a_en = w_accept;
    assign w_inc_b_en = w_commit & (w_ev_class == EV_ZERO);

`ifdef CLEAR_ON_READ_EN
    assign w_cor_fire = w_rd_fire;
`else
    assign w_cor_fire = 1'b0;
`endif

    always_comb begin
        w_inc_a_addr = {1'b0, w_ev_bin};
        case (w_ev_class)
            EV_H21:  w_inc_a_addr = c_H21_BASE + 7'(w_ev_bin);
            EV_ZERO: w_inc_a_addr = '0;
            default: w_inc_a_addr = {1'b0, w_ev_bin};
        endcase
    end

    // A bin cleared by a read in the same cycle counts up from zero.
    assign w_base_a = (w_cor_fire && rd.rd_addr == w_inc_a_addr) ? '0 : r_bins[w_inc_a_addr];
    assign w_base_b = (w_cor_fire && rd.rd_addr == c_H21_BASE)   ? '0 : r_bins[c_H21_BASE];

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_sweeping) begin
                r_bins[r_sweep_addr] <= '0;
            end else begin
                if (w_cor_fire)
                    r_bins[rd.rd_addr] <= '0;
                if (w_inc_a_en)
                    r_bins[w_inc_a_addr] <= sat_inc(w_base_a);
                if (w_inc_b_en)
                    r_bins[c_H21_BASE] <= sat_inc(w_base_b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_SWEEP;
            r_sweep_addr  <= '0;
            r_busy        <= 1'b1;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
            r_event_count <= '0;
            r_drop_count  <= '0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire)
                r_rd_data <= r_bins[rd.rd_addr];

            case (r_state)
                c_ST_IDLE: begin
                    if (clear) begin
                        r_state      <= c_ST_SWEEP;
                        r_busy       <= 1'b1;
                        r_sweep_addr <= '0;
                    end
                end
                default: begin
                    r_sweep_addr <= r_sweep_addr + 7'd1;
                    if (r_sweep_addr == c_LAST) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase

            if (clear && !w_sweeping) begin
                r_event_count <= '0;
                r_drop_count  <= '0;
            end else begin
                if (w_accept && !(&r_event_count))
                    r_event_count <= r_event_count + CNT_W'(1);
                if (w_drop && !(&r_drop_count))
                    r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign busy        = r_busy;
    assign rd.rd_valid = r_rd_valid;
    assign rd.rd_data  = r_rd_data;
    assign event_count = r_event_count;
    assign drop_count  = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_coincidence_histogram.sv
// ============================================================================
//  Module      : tb_coincidence_histogram
//  Description : Directed bench; a second instance with 2-bit bins/counters
//                shares the stimulus to exercise saturation.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_coincidence_histogram;

`ifdef CLEAR_ON_READ_EN
    localparam bit c_COR = 1'b1;
`else
    localparam bit c_COR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start_sig = '0;
    logic [1:0]  end_sig = '0;
    logic [5:0]  interval = '0;
    logic        data_arrived = 1'b0;
    logic        acq_en = 1'b1;
    logic        clear = 1'b0;
    logic        rd_req = 1'b0;
    logic [6:0]  rd_addr = '0;

    logic        busy_b, busy_s;
    logic [31:0] ev_b;
    logic [1:0]  ev_s;
    logic [15:0] drop_b, drop_s;

    coincidence_histogram_if #(.BIN_W(16)) rd_b ();
    coincidence_histogram_if #(.BIN_W(2))  rd_s ();

    assign rd_b.rd_req  = rd_req;
    assign rd_b.rd_addr = rd_addr;
    assign rd_s.rd_req  = rd_req;
    assign rd_s.rd_addr = rd_addr;

    coincidence_histogram #(.BIN_W(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .START_signal(start_sig), .END_signal(end_sig),
        .INTERVAL(interval), .data_arrived(data_arrived), .acq_en(acq_en),
        .clear(clear), .busy(busy_b), .rd(rd_b.slave),
        .event_count(ev_b), .drop_count(drop_b)
    );

    coincidence_histogram #(.BIN_W(2), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .START_signal(start_sig), .END_signal(end_sig),
        .INTERVAL(interval), .data_arrived(data_arrived), .acq_en(acq_en),
        .clear(clear), .busy(busy_s), .rd(rd_s.slave),
        .event_count(ev_s), .drop_count(drop_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         do_ev;
        bit         acq;
        logic [1:0] st;
        logic [1:0] en;
        logic [5:0] iv;
        int         len;
        logic [6:0] raddr;
        int         exp_bin;
        int         exp_bin_cor;
        int         exp_ev;
        int         exp_drop;
    } vec_t;

    vec_t vecs [15];

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_event(input logic [1:0] st, input logic [1:0] en,
                              input logic [5:0] iv, input int len);
        start_sig    = st;
        end_sig      = en;
        interval     = iv;
        data_arrived = 1'b1;
        repeat (len) tick();
        data_arrived = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [6:0] a, input string name, input int exp);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        rd_req  = 1'b0;
        check({name, " valid"}, longint'(rd_b.rd_valid), 1);
        check(name, longint'(rd_b.rd_data), exp);
        check({name, " small"}, longint'(rd_s.rd_data), sat3(exp));
        tick();
        check({name, " valid pulse"}, longint'(rd_b.rd_valid), 0);
    endtask

    task automatic check_counts(input string name, input int exp_ev, input int exp_drop);
        check({name, " event_count"}, longint'(ev_b), exp_ev);
        check({name, " event_count small"}, longint'(ev_s), sat3(exp_ev));
        check({name, " drop_count"}, longint'(drop_b), exp_drop);
        check({name, " drop_count small"}, longint'(drop_s), exp_drop);
    endtask

    task automatic wait_busy(input string name);
        int cnt;
        cnt = 0;
        while (busy_b && cnt < 300) begin
            tick();
            cnt++;
        end
        check({name, " busy cycles"}, cnt, 128);
        check({name, " busy low"}, longint'(busy_b), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  saw_valid;

        //            ev acq st     en     iv len addr  N  COR ev drop
        vecs[0]  = '{1, 1, 2'b01, 2'b10, 6'd10, 2, 7'd10,  1, 1, 1, 0};
        vecs[1]  = '{1, 1, 2'b00, 2'b11, 6'd0,  1, 7'd0,   1, 1, 2, 0};
        vecs[2]  = '{0, 1, 2'b00, 2'b00, 6'd0,  1, 7'd64,  1, 1, 2, 0};
        vecs[3]  = '{1, 1, 2'b01, 2'b01, 6'd5,  1, 7'd5,   0, 0, 2, 1};
        vecs[4]  = '{1, 1, 2'b10, 2'b01, 6'd63, 1, 7'd127, 1, 1, 3, 1};
        vecs[5]  = '{1, 1, 2'b10, 2'b01, 6'd63, 2, 7'd127, 2, 1, 4, 1};
        vecs[6]  = '{1, 0, 2'b01, 2'b10, 6'd10, 1, 7'd10,  1, 0, 4, 1};
        vecs[7]  = '{1, 1, 2'b00, 2'b00, 6'd3,  1, 7'd3,   0, 0, 4, 2};
        vecs[8]  = '{1, 1, 2'b10, 2'b01, 6'd0,  1, 7'd64,  2, 1, 5, 2};
        vecs[9]  = '{1, 1, 2'b11, 2'b10, 6'd10, 1, 7'd10,  1, 0, 5, 3};
        vecs[10] = '{1, 1, 2'b01, 2'b11, 6'd20, 1, 7'd0,   2, 1, 6, 3};
        vecs[11] = '{0, 1, 2'b00, 2'b00, 6'd0,  1, 7'd64,  3, 1, 6, 3};
        vecs[12] = '{1, 1, 2'b10, 2'b01, 6'd63, 1, 7'd127, 3, 1, 7, 3};
        vecs[13] = '{1, 1, 2'b10, 2'b01, 6'd63, 1, 7'd127, 4, 1, 8, 3};
        vecs[14] = '{1, 1, 2'b10, 2'b10, 6'd7,  1, 7'd7,   0, 0, 8, 4};

        // Reset state
        repeat (3) tick();
        check("reset busy", longint'(busy_b), 1);
        check("reset rd_valid", longint'(rd_b.rd_valid), 0);
        check("reset rd_data", longint'(rd_b.rd_data), 0);
        check_counts("reset", 0, 0);
        rst = 1'b0;
        wait_busy("post-reset sweep");
        do_read(7'd5, "read addr5 after reset", 0);

        // Table of single events, each followed by a bin read
        for (int i = 0; i < 15; i++) begin
            acq_en = vecs[i].acq;
            if (vecs[i].do_ev)
                send_event(vecs[i].st, vecs[i].en, vecs[i].iv, vecs[i].len);
            acq_en = 1'b1;
            do_read(vecs[i].raddr, $sformatf("vec%0d bin", i),
                    c_COR ? vecs[i].exp_bin_cor : vecs[i].exp_bin);
            check_counts($sformatf("vec%0d", i), vecs[i].exp_ev, vecs[i].exp_drop);
        end

        // Read lands on the same edge as the increment of that bin
        start_sig = 2'b01; end_sig = 2'b10; interval = 6'd10;
        data_arrived = 1'b1;
        tick();
        data_arrived = 1'b0;
        rd_req = 1'b1; rd_addr = 7'd10;
        tick();
        rd_req = 1'b0;
        check("same-edge read valid", longint'(rd_b.rd_valid), 1);
        check("same-edge read old value", longint'(rd_b.rd_data), c_COR ? 0 : 1);
        tick();
        do_read(7'd10, "bin after same-edge inc", c_COR ? 1 : 2);
        check_counts("same-edge", 9, 4);

        // H12[7]=4, then two back-to-back reads of address 7
        repeat (4) send_event(2'b01, 2'b10, 6'd7, 1);
        rd_req = 1'b1; rd_addr = 7'd7;
        tick();
        check("b2b read1 valid", longint'(rd_b.rd_valid), 1);
        check("b2b read1 data", longint'(rd_b.rd_data), 4);
        tick();
        rd_req = 1'b0;
        check("b2b read2 valid", longint'(rd_b.rd_valid), 1);
        check("b2b read2 data", longint'(rd_b.rd_data), c_COR ? 0 : 4);
        check("b2b read2 small", longint'(rd_s.rd_data), c_COR ? 0 : 3);
        tick();
        check_counts("after H12[7] events", 13, 4);

        // Clear sweep with an event at sweep cycle 50, a re-clear and a read while busy
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear busy rises", longint'(busy_b), 1);
        check_counts("clear edge", 0, 0);
        cnt = 0;
        saw_valid = 1'b0;
        while (busy_b && cnt < 300) begin
            if (cnt == 49) begin
                start_sig = 2'b01; end_sig = 2'b10; interval = 6'd10;
                data_arrived = 1'b1;
            end
            if (cnt == 50) data_arrived = 1'b0;
            if (cnt == 60) clear = 1'b1;
            if (cnt == 61) clear = 1'b0;
            if (cnt == 70) begin rd_req = 1'b1; rd_addr = 7'd0; end
            if (cnt == 71) rd_req = 1'b0;
            tick();
            cnt++;
            if (rd_b.rd_valid) saw_valid = 1'b1;
        end
        check("clear busy cycles", cnt, 128);
        check("rd_valid while busy", longint'(saw_valid), 0);
        check_counts("after clear", 0, 1);
        do_read(7'd0,   "cleared bin 0",   0);
        do_read(7'd10,  "cleared bin 10",  0);
        do_read(7'd64,  "cleared bin 64",  0);
        do_read(7'd127, "cleared bin 127", 0);
        do_read(7'd7,   "cleared bin 7",   0);

        // Reset in the middle of a sweep with a capture pending
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (30) tick();
        start_sig = 2'b10; end_sig = 2'b01; interval = 6'd5;
        data_arrived = 1'b1;
        tick();
        data_arrived = 1'b0;
        rst = 1'b1;
        tick();
        check("mid-sweep rst busy", longint'(busy_b), 1);
        check("mid-sweep rst rd_valid", longint'(rd_b.rd_valid), 0);
        check_counts("mid-sweep rst", 0, 0);
        rst = 1'b0;
        wait_busy("restarted sweep");
        check_counts("after restarted sweep", 0, 0);
        send_event(2'b10, 2'b01, 6'd5, 1);
        do_read(7'd69, "H21[5] after restart", 1);
        check_counts("after restart event", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
